// File: rtl/dpll_pkg.sv
// Purpose: shared types and constants for the DPLL code controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpll_pkg;

  localparam int CODE_W    = 8;
  localparam int SAR_BIT_W = $clog2(CODE_W);

  // Default loop timing and thresholds.
  localparam int unsigned       SETTLE_CYC_DEF = 16;
  localparam int unsigned       LOCK_CNT_DEF   = 8;
  localparam int unsigned       UNLOCK_RUN_DEF = 4;
  localparam logic [CODE_W-1:0] CODE_INIT_DEF  = 8'h80;

  // Acquisition always begins with only the MSB set, trialling the MSB.
  localparam logic [CODE_W-1:0]    SAR_START = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [SAR_BIT_W-1:0] SAR_MSB   = SAR_BIT_W'(CODE_W-1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAR    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // One tracking step, saturating at both ends of the code range.
  function automatic logic [CODE_W-1:0] sat_step(input logic [CODE_W-1:0] c,
                                                  input logic up);
    if (up) return (&c) ? c : c + CODE_W'(1);
    else    return (c == '0) ? c : c - CODE_W'(1);
  endfunction

endpackage

// File: rtl/dpll_sync2.sv
// Purpose: two-flop synchronizer for one asynchronous active-low phase request.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (sync, active-high, flops reset to 1 = idle), d_i async in, q_o synced out.
module dpll_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dpll_code_ctrl.sv
// Purpose: DPLL loop controller: SAR acquisition of the DCO code, then +/-1 tracking with lock detect.
// Latency: one code/lock update per SETTLE_CYC clk cycles; inputs see 2 cycles of synchronizer delay.
// Backpressure: none; a step with no valid phase decision is simply retried after another settle interval.
// Ports: clk, rst (sync active-high), en (low forces IDLE), p_up/p_down (async, active-low requests),
//        code (registered DCO word), lock (registered), state_dbg (FSM state encoding).
// Build option: define LOCK_LOSS_RESAR_EN to restart full SAR acquisition on loss of lock
//               instead of resuming tracking from the current code.
module dpll_code_ctrl
  import dpll_pkg::*;
#(
  parameter int unsigned       SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned       LOCK_CNT   = LOCK_CNT_DEF,
  parameter int unsigned       UNLOCK_RUN = UNLOCK_RUN_DEF,
  parameter logic [CODE_W-1:0] CODE_INIT  = CODE_INIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              p_up,
  input  logic              p_down,
  output logic [CODE_W-1:0] code,
  output logic              lock,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(SETTLE_CYC);
  localparam int REV_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W = $clog2(UNLOCK_RUN + 1);

  logic p_up_s;
  logic p_down_s;

  dpll_sync2 u_sync_up (.clk(clk), .rst(rst), .d_i(p_up),   .q_o(p_up_s));
  dpll_sync2 u_sync_dn (.clk(clk), .rst(rst), .d_i(p_down), .q_o(p_down_s));

  // Exactly one request asserted is a decision; both or neither is "no decision".
  logic dec_up, dec_dn, dec_vld;
  assign dec_up  = !p_up_s &&  p_down_s;
  assign dec_dn  =  p_up_s && !p_down_s;
  assign dec_vld = dec_up || dec_dn;

  state_e               state_q,    state_d;
  logic [CODE_W-1:0]    code_q,     code_d;
  logic                 lock_q,     lock_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [SAR_BIT_W-1:0] bit_q,      bit_d;
  logic [REV_W-1:0]     rev_q,      rev_d;
  logic [RUN_W-1:0]     run_q,      run_d;
  logic                 prev_vld_q, prev_vld_d;
  logic                 prev_up_q,  prev_up_d;

  logic              settle_done;
  logic [CODE_W-1:0] step_code;
  logic              is_same;
  logic              is_rev;

  assign settle_done = (cnt_q == CNT_W'(SETTLE_CYC - 1));
  assign step_code   = sat_step(code_q, dec_up);
  assign is_same     = prev_vld_q && (prev_up_q == dec_up);
  assign is_rev      = prev_vld_q && (prev_up_q != dec_up);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    rev_d      = rev_q;
    run_d      = run_q;
    prev_vld_d = prev_vld_q;
    prev_up_d  = prev_up_q;

    if (!en) begin
      state_d    = ST_IDLE;
      code_d     = CODE_INIT;
      lock_d     = 1'b0;
      cnt_d      = '0;
      bit_d      = SAR_MSB;
      rev_d      = '0;
      run_d      = '0;
      prev_vld_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SAR;
      code_d  = SAR_START;
      bit_d   = SAR_MSB;
      cnt_d   = '0;
    end else if (!settle_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      // Every evaluation point restarts the settle interval, decision or not.
      cnt_d = '0;
      if (dec_vld) begin
        case (state_q)
          ST_SAR: begin
            code_d[bit_q] = dec_up;
            if (bit_q != '0) begin
              bit_d                      = bit_q - SAR_BIT_W'(1);
              code_d[bit_q-SAR_BIT_W'(1)] = 1'b1;
            end else begin
              state_d    = ST_TRACK;
              rev_d      = '0;
              prev_vld_d = 1'b0;
            end
          end
          ST_TRACK: begin
            code_d     = step_code;
            prev_vld_d = 1'b1;
            prev_up_d  = dec_up;
            if (is_rev) begin
              if (rev_q == REV_W'(LOCK_CNT - 1)) begin
                state_d = ST_LOCKED;
                lock_d  = 1'b1;
                rev_d   = '0;
                run_d   = '0;
              end else begin
                rev_d = rev_q + REV_W'(1);
              end
            end else if (is_same) begin
              rev_d = '0;
            end
          end
          ST_LOCKED: begin
            code_d     = step_code;
            prev_vld_d = 1'b1;
            prev_up_d  = dec_up;
            if (is_same) begin
              if (run_q == RUN_W'(UNLOCK_RUN - 1)) begin
                lock_d = 1'b0;
                run_d  = '0;
                rev_d  = '0;
`ifdef LOCK_LOSS_RESAR_EN
                state_d = ST_SAR;
                code_d  = SAR_START;
                bit_d   = SAR_MSB;
`else
                state_d = ST_TRACK;
`endif
              end else begin
                run_d = run_q + RUN_W'(1);
              end
            end else begin
              run_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= CODE_INIT;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= SAR_MSB;
      rev_q      <= '0;
      run_q      <= '0;
      prev_vld_q <= 1'b0;
      prev_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rev_q      <= rev_d;
      run_q      <= run_d;
      prev_vld_q <= prev_vld_d;
      prev_up_q  <= prev_up_d;
    end
  end

  assign code      = code_q;
  assign lock      = lock_q;
  assign state_dbg = state_q;

endmodule
